bus_arbiter_4x1: RTL and testbench



---
 rtl/bus_arbiter_4x1.sv | 133 +++++++++++++
 tb/tb_bus_arbiter_4x1.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_4x1.sv
// Round-robin 4:1 bus arbiter: grants one requester at a time, drives the mux
// select and forwards that requester's beats under a valid/ready handshake.
module bus_arbiter_4x1 #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Req,
  input  logic [3:0]       Last,
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [WIDTH-1:0] In3,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  output logic [1:0]       Sel,
  output logic [3:0]       Grant,
  output logic             Busy
);

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_t;

  localparam logic [3:0] BurstLimit = 4'(MAX_BURST);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  beatCnt_q, beatCnt_d;

  logic [7:0]  reqDouble;
  logic [3:0]  reqRot;
  logic        pickValid;
  logic [1:0]  pickOffset;
  logic [1:0]  pickIdx;
  logic        selReq;
  logic        selLast;
  logic        accept;
  logic        releaseNow;

  // Rotate requests so bit 0 is the current highest-priority requester.
  assign reqDouble = {Req, Req} >> ptr_q;
  assign reqRot    = reqDouble[3:0];

  always_comb begin
    pickValid  = 1'b1;
    pickOffset = 2'd0;
    casez (reqRot)
      4'b???1: pickOffset = 2'd0;
      4'b??10: pickOffset = 2'd1;
      4'b?100: pickOffset = 2'd2;
      4'b1000: pickOffset = 2'd3;
      default: pickValid  = 1'b0;
    endcase
  end

  assign pickIdx  = ptr_q + pickOffset;
  assign selReq   = Req[sel_q];
  assign selLast  = Last[sel_q];
  assign OutValid = (state_q == StBusy) && selReq;
  assign Busy     = (state_q == StBusy);
  assign accept   = OutValid && OutReady;

  // Last beat, burst limit or a dropped request all end the grant.
  assign releaseNow = (state_q == StBusy) &&
                      (!selReq ||
                       (accept && (selLast || ((beatCnt_q + 4'd1) == BurstLimit))));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      StIdle: begin
        if (pickValid) begin
          state_d   = StBusy;
          sel_d     = pickIdx;
          grant_d   = 4'b0001 << pickIdx;
          ptr_d     = pickIdx + 2'd1;
          beatCnt_d = 4'd0;
        end
      end
      StBusy: begin
        if (releaseNow) begin
          state_d   = StIdle;
          grant_d   = 4'd0;
          beatCnt_d = 4'd0;
        end else if (accept) begin
          beatCnt_d = beatCnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      grant_q   <= 4'd0;
      beatCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  always_comb begin
    Out = In0;
    case (sel_q)
      2'd0: Out = In0;
      2'd1: Out = In1;
      2'd2: Out = In2;
      2'd3: Out = In3;
      default: Out = In0;
    endcase
  end

  assign Sel   = sel_q;
  assign Grant = grant_q;

endmodule

// File: tb/tb_bus_arbiter_4x1.sv
// Directed bench for bus_arbiter_4x1: a per-cycle vector table for the basic
// grant/rotation behaviour, then hand-written burst, stall, abort and reset sequences.
module tb_bus_arbiter_4x1;

  logic        clk;
  logic        reset;
  logic [3:0]  Req;
  logic [3:0]  Last;
  logic [31:0] In0, In1, In2, In3;
  logic        OutReady;
  logic [31:0] Out;
  logic        OutValid;
  logic [1:0]  Sel;
  logic [3:0]  Grant;
  logic        Busy;

  int testsRun;
  int testsFailed;

  logic [31:0] dataOf [4];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] expGrant;
    logic [1:0] expSel;
    logic       expValid;
    logic       expBusy;
  } vec_t;

  vec_t vecs [15];

  bus_arbiter_4x1 #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Last(Last),
    .In0(In0), .In1(In1), .In2(In2), .In3(In3),
    .OutReady(OutReady), .Out(Out), .OutValid(OutValid),
    .Sel(Sel), .Grant(Grant), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge so they are stable around the rising edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] req,
                               input logic [3:0] last, input logic rdy);
    @(negedge clk);
    reset    = rst;
    Req      = req;
    Last     = last;
    OutReady = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expGrant,
                             input logic [1:0] expSel, input logic expValid,
                             input logic expBusy);
    testsRun++;
    if (Grant !== expGrant) begin
      testsFailed++;
      $display("[TB] FAIL %s Grant got %b expected %b", name, Grant, expGrant);
    end
    testsRun++;
    if (Sel !== expSel) begin
      testsFailed++;
      $display("[TB] FAIL %s Sel got %0d expected %0d", name, Sel, expSel);
    end
    testsRun++;
    if (OutValid !== expValid) begin
      testsFailed++;
      $display("[TB] FAIL %s OutValid got %b expected %b", name, OutValid, expValid);
    end
    testsRun++;
    if (Busy !== expBusy) begin
      testsFailed++;
      $display("[TB] FAIL %s Busy got %b expected %b", name, Busy, expBusy);
    end
    testsRun++;
    if (Out !== dataOf[expSel]) begin
      testsFailed++;
      $display("[TB] FAIL %s Out got %h expected %h", name, Out, dataOf[expSel]);
    end
  endtask

  task automatic stepCheck(input string name, input logic [3:0] req,
                           input logic [3:0] last, input logic rdy,
                           input logic [3:0] expGrant, input logic [1:0] expSel,
                           input logic expValid, input logic expBusy);
    applyStimulus(1'b0, req, last, rdy);
    checkOutput(name, expGrant, expSel, expValid, expBusy);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    In0 = 32'h1111_0000;
    In1 = 32'h2222_1111;
    In2 = 32'hDEAD_BEEF;
    In3 = 32'h3333_3333;
    dataOf[0] = In0;
    dataOf[1] = In1;
    dataOf[2] = In2;
    dataOf[3] = In3;
    reset = 1'b1; Req = 4'd0; Last = 4'd0; OutReady = 1'b0;

    // Single grant to requester 2, then a reset and full 4-way contention from Ptr=0.
    //            rst   req      last     rdy   grant    sel   vld   busy
    vecs[0]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expSel,
                  vecs[i].expValid, vecs[i].expBusy);
    end

    // Burst limit: requester 1 never marks Last, so four beats end the grant.
    // Ptr is 1 here; with Req[2] low requester 1 is regranted after the bubble.
    stepCheck("burstIdle", 4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++)
      stepCheck($sformatf("burstBeat%0d", b), 4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    stepCheck("burstBubble", 4'b0010, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    stepCheck("regrantBeat0", 4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    // Req[2] rising mid-grant is ignored until the next idle cycle.
    for (int b = 1; b < 4; b++)
      stepCheck($sformatf("regrantBeat%0d", b), 4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    stepCheck("regrantBubble", 4'b0110, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    stepCheck("nextIsReq2", 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);

    // Stall during a grant to requester 3: count must hold across the stall.
    stepCheck("stallIdle", 4'b1000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    stepCheck("stallBeat0", 4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1);
    for (int s = 0; s < 3; s++)
      stepCheck($sformatf("stallHold%0d", s), 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1);
    for (int b = 1; b < 4; b++)
      stepCheck($sformatf("stallBeat%0d", b), 4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1);
    stepCheck("stallRelease", 4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);

    // Abort: requester 0 drops its request after one beat; Ptr ends at 1.
    stepCheck("abortBeat", 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);
    stepCheck("abortDrop", 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1);
    stepCheck("abortIdle", 4'b0011, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    stepCheck("abortPtr1", 4'b0100, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1);

    // Reset in the middle of a burst from requester 2 after two beats.
    stepCheck("rstIdle", 4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    stepCheck("rstBeat0", 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);
    stepCheck("rstBeat1", 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b1);
    checkOutput("rstCycle", 4'b0100, 2'd2, 1'b1, 1'b1);
    stepCheck("rstAfter", 4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    stepCheck("rstGrant0", 4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
